// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the i2c request scheduler.
package i2c_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RECOVER,
      RESP
   } sched_state_e;

   typedef struct packed {
      logic       read;
      logic [7:0] addr;
      logic [7:0] sreg;
      logic [7:0] data;
   } i2c_req_t;

   localparam int RECOVER_CYCLES = 2;
   // idle cycles after a response so done->grant spans at least 4 cycles
   localparam int GAP_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          valid
);

   localparam int SW = IW + 1;

   logic [N-1:0]  rot;
   logic [SW-1:0] sum;

   always_comb begin
      rot     = N'({req, req} >> ptr);
      sum     = '0;
      gnt_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum     = {1'b0, ptr} + SW'(i);
            gnt_idx = (sum >= SW'(N)) ? IW'(sum - SW'(N))
                                      : sum[IW-1:0];
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/i2c_req_sched.sv
// Round-robin scheduler sharing one i2c master among NUM_REQ requesters,
// with watchdog recovery and per-requester responses.
module i2c_req_sched
   import i2c_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TMO_W   = 20
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic [TMO_W-1:0]        timeout_i,
   input  logic [NUM_REQ-1:0]      req_i,
   input  logic [NUM_REQ-1:0]      req_read_i,
   input  logic [NUM_REQ-1:0][7:0] req_addr_i,
   input  logic [NUM_REQ-1:0][7:0] req_reg_i,
   input  logic [NUM_REQ-1:0][7:0] req_data_i,
   output logic [NUM_REQ-1:0]      gnt_o,
   output logic [NUM_REQ-1:0]      done_o,
   output logic [7:0]              rsp_data_o,
   output logic                    rsp_err_o,
   output logic                    rsp_tmo_o,
   output logic                    m_enable_o,
   output logic                    m_start_o,
   output logic                    m_read_o,
   output logic [7:0]              m_addr_o,
   output logic [7:0]              m_reg_o,
   output logic [7:0]              m_data_o,
   input  logic                    m_ready_i,
   input  logic                    m_error_i,
   input  logic [7:0]              m_data_i
);

   localparam int IW = $clog2(NUM_REQ);

   sched_state_e        state;
   i2c_req_t            cur;
   logic [IW-1:0]       rr_ptr, idx, arb_idx, nxt_ptr;
   logic [NUM_REQ-1:0]  idx_oh;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [1:0]          rec_cnt, gap_cnt;
   logic                arb_valid, busy, tmo_hit, abort;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_i),
      .ptr     (rr_ptr),
      .gnt_idx (arb_idx),
      .valid   (arb_valid)
   );

   assign nxt_ptr = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
   assign idx_oh  = NUM_REQ'(1) << idx;
   assign busy    = (state == WAIT_BUSY) || (state == WAIT_DONE);
   assign tmo_hit = (timeout_i != '0) &&
                    (tmo_cnt == timeout_i - TMO_W'(1));
   assign abort   = !en_i && (state != IDLE) && (state != RESP);

   assign m_read_o = cur.read;
   assign m_addr_o = cur.addr;
   assign m_reg_o  = cur.sreg;
   assign m_data_o = cur.data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         cur        <= '0;
         idx        <= '0;
         rr_ptr     <= '0;
         tmo_cnt    <= '0;
         rec_cnt    <= '0;
         gap_cnt    <= '0;
         gnt_o      <= '0;
         done_o     <= '0;
         rsp_data_o <= '0;
         rsp_err_o  <= 1'b0;
         rsp_tmo_o  <= 1'b0;
         m_enable_o <= 1'b0;
         m_start_o  <= 1'b0;
      end else begin
         gnt_o      <= '0;
         done_o     <= '0;
         m_start_o  <= 1'b0;
         m_enable_o <= en_i;
         if (busy && tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
         if (abort) begin
            state      <= RESP;
            done_o     <= idx_oh;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
            rsp_tmo_o  <= 1'b0;
            if (state == ISSUE) rr_ptr <= nxt_ptr;
         end else begin
            unique case (state)
               IDLE: begin
                  if (gap_cnt != '0) begin
                     gap_cnt <= gap_cnt - 2'd1;
                  end else if (en_i && m_ready_i && arb_valid) begin
                     idx       <= arb_idx;
                     cur       <= '{read: req_read_i[arb_idx],
                                    addr: req_addr_i[arb_idx],
                                    sreg: req_reg_i[arb_idx],
                                    data: req_data_i[arb_idx]};
                     gnt_o     <= NUM_REQ'(1) << arb_idx;
                     m_start_o <= 1'b1;
                     state     <= ISSUE;
                  end
               end
               ISSUE: begin
                  rr_ptr  <= nxt_ptr;
                  tmo_cnt <= '0;
                  state   <= WAIT_BUSY;
               end
               WAIT_BUSY: begin
                  if (tmo_hit) begin
                     m_enable_o <= 1'b0;
                     rec_cnt    <= '0;
                     state      <= RECOVER;
                  end else if (!m_ready_i) begin
                     state <= WAIT_DONE;
                  end
               end
               WAIT_DONE: begin
                  if (m_ready_i) begin
                     done_o     <= idx_oh;
                     rsp_err_o  <= m_error_i;
                     rsp_tmo_o  <= 1'b0;
                     rsp_data_o <= (cur.read && !m_error_i) ? m_data_i
                                                             : 8'h00;
                     state      <= RESP;
                  end else if (tmo_hit) begin
                     m_enable_o <= 1'b0;
                     rec_cnt    <= '0;
                     state      <= RECOVER;
                  end
               end
               RECOVER: begin
                  if (rec_cnt == 2'(RECOVER_CYCLES - 1)) begin
                     done_o     <= idx_oh;
                     rsp_err_o  <= 1'b1;
                     rsp_tmo_o  <= 1'b1;
                     rsp_data_o <= '0;
                     state      <= RESP;
                  end else begin
                     m_enable_o <= 1'b0;
                     rec_cnt    <= rec_cnt + 2'd1;
                  end
               end
               RESP: begin
                  gap_cnt <= 2'(GAP_CYCLES);
                  state   <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_req_sched.sv
// Self-checking bench for i2c_req_sched with a stub master and
// a requester-level reference model of arbitration and responses.
module tb_i2c_req_sched;

   localparam int N  = 4;
   localparam int TW = 20;

   logic              clk = 1'b0;
   logic              rst, en;
   logic [TW-1:0]     timeout;
   logic [N-1:0]      req, req_read, gnt, done, seen;
   logic [N-1:0][7:0] req_addr, req_reg, req_data;
   logic [7:0]        rsp_data, m_addr, m_reg, m_wdata, m_rdata;
   logic              rsp_err, rsp_tmo, m_enable, m_start, m_read;
   logic              m_ready, m_error, en_seen;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int exp_ptr = 0;
   int last_done = -1;
   int won;
   int rr_order[4] = '{3, 1, 3, 1};

   i2c_req_sched #(.NUM_REQ(N), .TMO_W(TW)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .timeout_i  (timeout),
      .req_i      (req),
      .req_read_i (req_read),
      .req_addr_i (req_addr),
      .req_reg_i  (req_reg),
      .req_data_i (req_data),
      .gnt_o      (gnt),
      .done_o     (done),
      .rsp_data_o (rsp_data),
      .rsp_err_o  (rsp_err),
      .rsp_tmo_o  (rsp_tmo),
      .m_enable_o (m_enable),
      .m_start_o  (m_start),
      .m_read_o   (m_read),
      .m_addr_o   (m_addr),
      .m_reg_o    (m_reg),
      .m_data_o   (m_wdata),
      .m_ready_i  (m_ready),
      .m_error_i  (m_error),
      .m_data_i   (m_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL global_timeout cycles=%0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         req_addr[i] = 8'($urandom);
         req_reg[i]  = 8'($urandom);
         req_data[i] = 8'($urandom);
      end
      req_read = 4'($urandom);
   endtask

   // mode 0: normal completion, 1: hung master, 2: en_i drop mid-transfer
   task automatic xfer(input string tag, input int mode, input int busy,
                       input logic err, input logic [7:0] rd,
                       output int w);
      int n, n0, low;
      logic [7:0] exp_d;
      logic [24:0] fld;
      w = -1;
      for (int i = 0; i < N; i++)
         if (w < 0 && req[(exp_ptr + i) % N]) w = (exp_ptr + i) % N;
      n = 0;
      while (gnt === '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (gnt === '0 || w < 0) begin
         chk({tag, "_gnt_seen"}, 64'(gnt != '0), 1);
         return;
      end
      n0 = cyc;
      fld = {req_read[w], req_addr[w], req_reg[w], req_data[w]};
      if (last_done < 0) chk({tag, "_gnt_lat"}, n, 1);
      else chk({tag, "_gap_ge4"}, 64'(n0 - last_done >= 4), 1);
      chk({tag, "_gnt"}, gnt, 1 << w);
      chk({tag, "_start"}, m_start, 1);
      chk({tag, "_fld"}, {m_read, m_addr, m_reg, m_wdata}, fld);
      exp_ptr = (w + 1) % N;
      req[w] = 1'b0;
      m_ready = 1'b0;
      repeat (busy) @(negedge clk);
      chk({tag, "_start_off"}, m_start, 0);
      if (mode == 0) begin
         m_ready = 1'b1;
         m_error = err;
         m_rdata = rd;
      end
      if (mode == 2) en = 1'b0;
      n = 0;
      low = 0;
      do begin
         @(negedge clk);
         n++;
         if (!m_enable) low++;
      end while (done === '0 && n < 300);
      chk({tag, "_done"}, done, 1 << w);
      if (mode == 0) begin
         exp_d = (fld[24] && !err) ? rd : 8'h00;
         chk({tag, "_done_lat"}, n, 1);
         chk({tag, "_rsp"}, {rsp_err, rsp_tmo, rsp_data}, {err, 1'b0, exp_d});
      end else if (mode == 1) begin
         chk({tag, "_tmo_cycle"}, cyc - n0, int'(timeout) + 3);
         chk({tag, "_recover_low"}, low, 2);
         chk({tag, "_rsp"}, {rsp_err, rsp_tmo, rsp_data}, {1'b1, 1'b1, 8'h00});
      end else begin
         chk({tag, "_abort_lat"}, n, 1);
         chk({tag, "_abort_men"}, m_enable, 0);
         chk({tag, "_rsp"}, {rsp_err, rsp_tmo, rsp_data}, {1'b1, 1'b0, 8'h00});
      end
      chk({tag, "_fld_resp"}, {m_read, m_addr, m_reg, m_wdata}, fld);
      last_done = cyc;
      m_ready = 1'b1;
      m_error = 1'b0;
      m_rdata = 8'h00;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_fld_after"}, {m_read, m_addr, m_reg, m_wdata}, fld);
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b1;
      timeout = 20'd1000;
      req = '0;
      rand_fields();
      m_ready = 1'b1;
      m_error = 1'b0;
      m_rdata = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_outs",
          {gnt, done, rsp_data, rsp_err, rsp_tmo, m_enable, m_start,
           m_read, m_addr, m_reg, m_wdata}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_men", m_enable, 1);

      req_read[0] = 1'b0;
      req_addr[0] = 8'hA0;
      req_reg[0]  = 8'h10;
      req_data[0] = 8'h5A;
      req = 4'b0001;
      xfer("wr_ack", 0, 40, 1'b0, 8'hEE, won);

      req_read[1] = 1'b1;
      req = 4'b0010;
      xfer("rd_nack", 0, 10, 1'b1, 8'hC3, won);

      rand_fields();
      for (int k = 0; k < 4; k++) begin
         req[1] = 1'b1;
         req[3] = 1'b1;
         xfer("rr", 0, $urandom_range(2, 10), 1'b0, 8'($urandom), won);
         chk("rr_order", won, rr_order[k]);
      end
      req = '0;

      timeout = 20'd100;
      req = 4'b0100;
      xfer("tmo", 1, 5, 1'b0, 8'h00, won);
      timeout = 20'd1000;

      req = 4'b0001;
      xfer("abort", 2, 10, 1'b0, 8'h00, won);
      req = '1;
      seen = '0;
      en_seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | gnt;
         en_seen = en_seen | m_enable;
      end
      chk("abort_no_gnt", seen, 0);
      chk("abort_men_off", en_seen, 0);
      en = 1'b1;
      xfer("reenable", 0, 4, 1'b0, 8'h3C, won);
      req = '0;

      timeout = '0;
      req = 4'b1000;
      req_read[3] = 1'b1;
      xfer("wdog_off", 0, 150, 1'b0, 8'h96, won);

      timeout = 20'd500;
      for (int k = 0; k < 25; k++) begin
         rand_fields();
         req = 4'($urandom_range(1, 15));
         xfer("rnd", 0, $urandom_range(2, 30), 1'($urandom),
              8'($urandom), won);
         req = '0;
         seen = '0;
         repeat (6) begin
            @(negedge clk);
            seen = seen | gnt | done;
         end
         chk("rnd_withdraw", seen, 0);
      end

      req = 4'b0001;
      @(negedge clk);
      chk("rst_mid_gnt", gnt, 1);
      req = '0;
      m_ready = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid_outs",
             {gnt, done, rsp_data, rsp_err, rsp_tmo, m_enable, m_start,
              m_read, m_addr, m_reg, m_wdata}, 0);
      m_ready = 1'b1;
      seen = '0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | done;
      end
      chk("rst_no_done", seen, 0);
      rst = 1'b0;
      exp_ptr = 0;
      last_done = -1;
      req = 4'b1100;
      xfer("post_rst", 0, 5, 1'b0, 8'h77, won);
      chk("post_rst_first", won, 2);
      req = '0;

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
